md_unit: RTL and testbench

Multiply/divide unit for the five-stage MIPS pipeline. It sits in the execute stage beside the ALU and consumes the same forwarded RS/RT operands. It owns the HI/LO registers and produces the MFHI/MFLO value that is captured by the E/M pipeline register. Multi-cycle operation is modelled with a busy counter, and the hazard unit uses `start`/`busy` to stall MD-dependent instructions.

---
 rtl/md_unit_pkg.sv | 42 ++++
 rtl/md_unit_core.sv | 51 +++++
 rtl/md_unit.sv | 92 +++++++++
 tb/tb_md_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared MD definitions: md_op encodings, width constant, default cycle counts.
// The MADD/MADDU decode is only active when MD_MADD_EN is defined.
package md_unit_pkg;

    localparam int MD_OP_W          = 4;
    localparam int DEF_MULT_CYCLES  = 5;
    localparam int DEF_DIV_CYCLES   = 10;

    typedef enum logic [MD_OP_W-1:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    function automatic logic is_div(input logic [MD_OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Without MD_MADD_EN the accumulate encodings fall through to "not multi-cycle".
    function automatic logic is_multi(input logic [MD_OP_W-1:0] op);
        logic r;
        r = (op == OP_MULT) || (op == OP_MULTU) || is_div(op);
`ifdef MD_MADD_EN
        r = r || (op == OP_MADD) || (op == OP_MADDU);
`endif
        return r;
    endfunction

endpackage

// File: rtl/md_unit_core.sv
// Pure combinational 64-bit {HI,LO} result for the op issued this cycle.
// Accumulate ops (MD_MADD_EN) add the product to the incoming HI/LO.
module md_unit_core
    import md_unit_pkg::*;
(
    input  logic [MD_OP_W-1:0] i_op,
    input  logic [31:0]        i_rs,
    input  logic [31:0]        i_rt,
    input  logic [31:0]        i_hi,
    input  logic [31:0]        i_lo,
    output logic [63:0]        o_result
);

    logic [63:0] w_rs_sx, w_rt_sx, w_prod_s, w_prod_u;
    logic        w_sdiv;
    logic [31:0] w_rs_mag, w_rt_mag, w_den, w_q_mag, w_r_mag, w_quot, w_rem;

    // Low 64 bits of a sign-extended product equal the signed 64-bit product.
    assign w_rs_sx  = {{32{i_rs[31]}}, i_rs};
    assign w_rt_sx  = {{32{i_rt[31]}}, i_rt};
    assign w_prod_s = w_rs_sx * w_rt_sx;
    assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

    // Signed divide on magnitudes; 0x80000000 / -1 wraps naturally to 0x80000000.
    assign w_sdiv   = (i_op == OP_DIV);
    assign w_rs_mag = (w_sdiv && i_rs[31]) ? (32'd0 - i_rs) : i_rs;
    assign w_rt_mag = (w_sdiv && i_rt[31]) ? (32'd0 - i_rt) : i_rt;
    assign w_den    = (i_rt == 32'd0) ? 32'd1 : w_rt_mag;
    assign w_q_mag  = w_rs_mag / w_den;
    assign w_r_mag  = w_rs_mag % w_den;
    assign w_quot   = (w_sdiv && (i_rs[31] ^ i_rt[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem    = (w_sdiv && i_rs[31]) ? (32'd0 - w_r_mag) : w_r_mag;

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        o_result = {i_hi, i_lo};
        case (i_op)
            OP_MULT:  o_result = w_prod_s;
            OP_MULTU: o_result = w_prod_u;
            OP_DIV, OP_DIVU: begin
                if (i_rt != 32'd0) o_result = {w_rem, w_quot};
            end
`ifdef MD_MADD_EN
            OP_MADD:  o_result = {i_hi, i_lo} + w_prod_s;
            OP_MADDU: o_result = {i_hi, i_lo} + w_prod_u;
`endif
            default:  ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Execute-stage multiply/divide unit owning HI/LO with a busy-counter latency model.
// Optional MADD/MADDU accumulate ops are enabled by defining MD_MADD_EN.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        rs_data,
    input  logic [31:0]        rt_data,
    output logic               start,
    output logic               busy,
    output logic [31:0]        md_out
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_state_e        r_state;
    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi, r_lo, r_pend_hi, r_pend_lo;
    logic [63:0]      w_result;
    logic [CNT_W-1:0] w_cycles;
    logic             w_start;

    md_unit_core u_core (
        .i_op     (md_op),
        .i_rs     (rs_data),
        .i_rt     (rt_data),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .o_result (w_result)
    );

    assign w_start  = (r_state == ST_IDLE) && is_multi(md_op);
    assign w_cycles = is_div(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    assign start  = w_start;
    assign busy   = r_busy;
    assign md_out = (md_op == OP_MFHI) ? r_hi :
                    (md_op == OP_MFLO) ? r_lo : 32'd0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_pend_hi <= w_result[63:32];
                        r_pend_lo <= w_result[31:0];
                        r_cnt     <= w_cycles;
                        r_busy    <= 1'b1;
                        r_state   <= ST_RUN;
                    end else if (md_op == OP_MTHI) begin
                        r_hi <= rs_data;
                    end else if (md_op == OP_MTLO) begin
                        r_lo <= rs_data;
                    end
                end
                ST_RUN: begin
                    // Any op presented while running is ignored; result commits on the last busy cycle.
                    if (r_cnt == CNT_W'(1)) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit (default cycle counts).
// MADD checks follow whichever way MD_MADD_EN is set for the build.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  md_op;
    logic [31:0] rs_data, rt_data;
    logic        start, busy;
    logic [31:0] md_out;

    int errors = 0;
    int checks = 0;

    md_unit dut (
        .clk     (clk),
        .reset   (reset),
        .md_op   (md_op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .start   (start),
        .busy    (busy),
        .md_out  (md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are sampled 2ns later, well before the rising edge.
    task automatic apply(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        md_op   = op;
        rs_data = rs;
        rt_data = rt;
        #2;
    endtask

    // Counts busy cycles following a start cycle; bounded so a stuck busy still terminates.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            apply(OP_NONE, 32'd0, 32'd0);
            if (busy !== 1'b1) break;
            n++;
        end
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        apply(OP_MFHI, 32'd0, 32'd0);
        hi = md_out;
        apply(OP_MFLO, 32'd0, 32'd0);
        lo = md_out;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        apply(OP_NONE, 32'd0, 32'd0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start_none got=%b exp=0", start); end
        apply(OP_MULT, 32'd1, 32'd1);
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL reset_start_mult got=%b exp=1", start); end
        apply(OP_MFHI, 32'd0, 32'd0);
        checks++; if (md_out !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", md_out); end
        apply(OP_MFLO, 32'd0, 32'd0);
        checks++; if (md_out !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", md_out); end
        reset = 1'b1;
        apply(OP_NONE, 32'd0, 32'd0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
    endtask

    task automatic test_mult;
        logic [31:0] hi, lo;
        apply(OP_MULT, 32'hFFFF_FFFF, 32'h2);
        checks++; if (start !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mult_start got=%b/%b exp=1/0", start, busy); end
        for (int k = 1; k <= 5; k++) begin
            if (k == 3) apply(OP_MULT, 32'h5, 32'h5);
            else        apply(OP_NONE, 32'd0, 32'd0);
            checks++; if (busy !== 1'b1 || start !== 1'b0) begin errors++; $display("FAIL mult_busy_c%0d got=%b/%b exp=1/0", k, busy, start); end
        end
        apply(OP_NONE, 32'd0, 32'd0);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_done got=%b exp=0", busy); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo got=%h exp=fffffffe", lo); end
    endtask

    task automatic test_multu;
        logic [31:0] hi, lo;
        apply(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL multu_start got=%b exp=1", start); end
        repeat (4) apply(OP_NONE, 32'd0, 32'd0);
        apply(OP_MFHI, 32'd0, 32'd0);
        checks++; if (busy !== 1'b1 || md_out !== 32'hFFFF_FFFF) begin errors++; $display("FAIL multu_last_busy got=%b/%h exp=1/ffffffff", busy, md_out); end
        apply(OP_MFHI, 32'd0, 32'd0);
        checks++; if (busy !== 1'b0 || md_out !== 32'h1) begin errors++; $display("FAIL multu_hi got=%b/%h exp=0/00000001", busy, md_out); end
        read_hilo(hi, lo);
        checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got=%h exp=fffffffe", lo); end
    endtask

    task automatic run_div(input string name, input logic [3:0] op, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        logic [31:0] hi, lo;
        apply(op, rs, rt);
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL %s_start got=%b exp=1", name, start); end
        count_busy(n);
        checks++; if (n != 10) begin errors++; $display("FAIL %s_busy_cycles got=%0d exp=10", name, n); end
        read_hilo(hi, lo);
        checks++; if (hi !== exp_hi) begin errors++; $display("FAIL %s_hi got=%h exp=%h", name, hi, exp_hi); end
        checks++; if (lo !== exp_lo) begin errors++; $display("FAIL %s_lo got=%h exp=%h", name, lo, exp_lo); end
    endtask

    task automatic test_div;
        run_div("div_neg",  OP_DIV,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_div("divu",     OP_DIVU, 32'h7,         32'h2,         32'h1,         32'h3);
        run_div("div_negd", OP_DIV,  32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD);
        run_div("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
        run_div("divu_big", OP_DIVU, 32'hFFFF_FFF9, 32'h2,         32'h1,         32'h7FFF_FFFC);
    endtask

    task automatic test_div_zero;
        apply(OP_MTHI, 32'h1234, 32'd0);
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL mthi_start got=%b exp=0", start); end
        apply(OP_MTLO, 32'h5678, 32'd0);
        apply(OP_MFHI, 32'd0, 32'd0);
        checks++; if (md_out !== 32'h1234 || busy !== 1'b0) begin errors++; $display("FAIL mthi_visible got=%h/%b exp=00001234/0", md_out, busy); end
        run_div("div_zero", OP_DIV, 32'hDEAD_BEEF, 32'h0, 32'h1234, 32'h5678);
    endtask

    task automatic test_reset_mid;
        logic [31:0] hi, lo;
        apply(OP_MULT, 32'h3, 32'h4);
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL rmid_start got=%b exp=1", start); end
        apply(OP_NONE, 32'd0, 32'd0);
        apply(OP_NONE, 32'd0, 32'd0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy got=%b exp=1", busy); end
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_async got=%b exp=0", busy); end
        repeat (5) apply(OP_NONE, 32'd0, 32'd0);
        reset = 1'b1;
        read_hilo(hi, lo);
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rmid_hilo got=%h/%h exp=0/0", hi, lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle got=%b exp=0", busy); end
    endtask

    task automatic test_madd;
        int n;
        logic [31:0] hi, lo;
        apply(OP_MTHI, 32'h0, 32'd0);
        apply(OP_MTLO, 32'hFFFF_FFFF, 32'd0);
        apply(OP_MADDU, 32'h1, 32'h1);
`ifdef MD_MADD_EN
        checks++; if (start !== 1'b1) begin errors++; $display("FAIL maddu_start got=%b exp=1", start); end
        count_busy(n);
        checks++; if (n != 5) begin errors++; $display("FAIL maddu_busy_cycles got=%0d exp=5", n); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'h1 || lo !== 32'h0) begin errors++; $display("FAIL maddu_hilo got=%h/%h exp=00000001/00000000", hi, lo); end
`else
        checks++; if (start !== 1'b0) begin errors++; $display("FAIL maddu_start got=%b exp=0", start); end
        count_busy(n);
        checks++; if (n != 0) begin errors++; $display("FAIL maddu_busy_cycles got=%0d exp=0", n); end
        read_hilo(hi, lo);
        checks++; if (hi !== 32'h0 || lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL maddu_hilo got=%h/%h exp=00000000/ffffffff", hi, lo); end
`endif
    endtask

    task automatic test_back_to_back;
        logic [31:0] hi, lo;
        apply(OP_MULTU, 32'h2, 32'h3);
        repeat (5) apply(OP_NONE, 32'd0, 32'd0);
        apply(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        checks++; if (start !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_start got=%b/%b exp=1/0", start, busy); end
        repeat (5) apply(OP_NONE, 32'd0, 32'd0);
        read_hilo(hi, lo);
        checks++; if (hi !== 32'h1 || lo !== 32'h0) begin errors++; $display("FAIL b2b_hilo got=%h/%h exp=00000001/00000000", hi, lo); end
    endtask

    initial begin
        md_op   = OP_NONE;
        rs_data = '0;
        rt_data = '0;
        reset   = 1'b0;
        test_reset;
        test_mult;
        test_multu;
        test_div;
        test_div_zero;
        test_reset_mid;
        test_madd;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
